// File: rtl/grey_hblur_pkg.sv
// -----------------------------------------------------------------------------
// grey_hblur_pkg
// Shared definitions for the grey_hblur3 horizontal smoothing stage:
//   - PIX_W   : width of one greyscale sample
//   - state_e : line-tracking state (EMPTY, HOLD, FLUSH)
//   - hblur3  : [1 2 1]/4 kernel on three samples
// Optional feature macro: GREY_HBLUR_ROUND_EN
//   defined   -> kernel rounds half-up (adds 2 before the shift)
//   undefined -> kernel truncates
// -----------------------------------------------------------------------------
package grey_hblur_pkg;

    localparam int unsigned PIX_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no pixel of the current line held
        HOLD  = 2'd1,   // at least one pixel held, line still open
        FLUSH = 2'd2    // tlast seen, last output still to be produced
    } state_e;

    // Sum is PIX_W+2 bits: max 255+510+255 = 1020 (1022 with rounding),
    // so dropping the two LSBs can never overflow PIX_W bits.
    function automatic logic [PIX_W-1:0] hblur3(
        input logic [PIX_W-1:0] prev,
        input logic [PIX_W-1:0] cur,
        input logic [PIX_W-1:0] nxt
    );
        logic [PIX_W+1:0] sum;
        sum = {2'b00, prev} + {1'b0, cur, 1'b0} + {2'b00, nxt};
`ifdef GREY_HBLUR_ROUND_EN
        sum = sum + (PIX_W+2)'(2);
`endif
        return sum[PIX_W+1:2];
    endfunction

endpackage

// File: rtl/grey_hblur3.sv
// -----------------------------------------------------------------------------
// grey_hblur3
// Horizontal 3-tap [1 2 1]/4 smoothing of greyscale video on AXI4-Stream.
// Edge pixels are replicated at both ends of each line; tuser/tlast travel
// with their pixels. Full backpressure on both sides.
//
// Ports:
//   aclk, areset                 clock, asynchronous active-high reset
//   s_axis_video_tdata  [3*PIX_W] input pixel, only [PIX_W-1:0] used
//   s_axis_video_tvalid/tready   input handshake
//   s_axis_video_tuser/tlast     start of frame / end of line
//   m_axis_video_tdata  [3*PIX_W] output {Y',Y',Y'}
//   m_axis_video_tvalid/tready   output handshake
//   m_axis_video_tuser/tlast     start of frame / end of line
//
// Optional feature macro: GREY_HBLUR_ROUND_EN (see grey_hblur_pkg::hblur3).
// -----------------------------------------------------------------------------
module grey_hblur3
    import grey_hblur_pkg::*;
(
    input  logic               aclk,
    input  logic               areset,
    input  logic [3*PIX_W-1:0] s_axis_video_tdata,
    input  logic               s_axis_video_tvalid,
    output logic               s_axis_video_tready,
    input  logic               s_axis_video_tuser,
    input  logic               s_axis_video_tlast,
    output logic [3*PIX_W-1:0] m_axis_video_tdata,
    output logic               m_axis_video_tvalid,
    input  logic               m_axis_video_tready,
    output logic               m_axis_video_tuser,
    output logic               m_axis_video_tlast
);

    state_e           state_q,     state_d;
    logic [PIX_W-1:0] prev_q,      prev_d;
    logic [PIX_W-1:0] cur_q,       cur_d;
    logic             sof_pend_q,  sof_pend_d;
    logic [PIX_W-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_user_q,  out_user_d;
    logic             out_last_q,  out_last_d;

    logic             out_load;
    logic             accept;
    logic [PIX_W-1:0] in_pix;

    // Upper colour lanes carry copies of Y and are deliberately dropped.
    logic unused_upper_lanes;
    assign unused_upper_lanes = ^s_axis_video_tdata[3*PIX_W-1:PIX_W];

    assign in_pix   = s_axis_video_tdata[PIX_W-1:0];

    // Output register may take a new value when empty or being drained.
    assign out_load = !out_valid_q || m_axis_video_tready;

    // FLUSH needs the output register for the line's last pixel, so input
    // stalls there; areset gating keeps tready low throughout reset.
    assign s_axis_video_tready = out_load && (state_q != FLUSH) && !areset;
    assign accept              = s_axis_video_tvalid && s_axis_video_tready;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        sof_pend_d  = sof_pend_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_user_d  = out_user_q;
        out_last_d  = out_last_q;

        // A drained output register empties unless reloaded below.
        if (out_load) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    // First pixel doubles as its own left neighbour.
                    prev_d     = in_pix;
                    cur_d      = in_pix;
                    sof_pend_d = s_axis_video_tuser;
                    state_d    = s_axis_video_tlast ? FLUSH : HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    out_data_d  = hblur3(prev_q, cur_q, in_pix);
                    out_valid_d = 1'b1;
                    out_user_d  = sof_pend_q;
                    out_last_d  = 1'b0;
                    prev_d      = cur_q;
                    cur_d       = in_pix;
                    sof_pend_d  = s_axis_video_tuser;
                    state_d     = s_axis_video_tlast ? FLUSH : HOLD;
                end
            end
            FLUSH: begin
                if (out_load) begin
                    // Last pixel doubles as its own right neighbour.
                    out_data_d  = hblur3(prev_q, cur_q, cur_q);
                    out_valid_d = 1'b1;
                    out_user_d  = sof_pend_q;
                    out_last_d  = 1'b1;
                    state_d     = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= EMPTY;
            prev_q      <= '0;
            cur_q       <= '0;
            sof_pend_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_user_q  <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            sof_pend_q  <= sof_pend_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_user_q  <= out_user_d;
            out_last_q  <= out_last_d;
        end
    end

    assign m_axis_video_tdata  = {3{out_data_q}};
    assign m_axis_video_tvalid = out_valid_q;
    assign m_axis_video_tuser  = out_user_q;
    assign m_axis_video_tlast  = out_last_q;

endmodule

// File: tb/tb_grey_hblur3.sv
// -----------------------------------------------------------------------------
// tb_grey_hblur3
// Self-checking bench for grey_hblur3. A line-level reference model computes
// the expected smoothed beats with plain arithmetic; a monitor compares every
// accepted output beat against them and checks stability under backpressure.
// Honours GREY_HBLUR_ROUND_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_grey_hblur3;
    import grey_hblur_pkg::*;

    logic        clk = 1'b0;
    logic        areset;
    logic [23:0] s_tdata;
    logic        s_tvalid, s_tready, s_tuser, s_tlast;
    logic [23:0] m_tdata;
    logic        m_valid, m_ready, m_tuser, m_tlast;
    logic        rand_bp;

    always #5 clk = ~clk;

    grey_hblur3 dut (
        .aclk                (clk),
        .areset              (areset),
        .s_axis_video_tdata  (s_tdata),
        .s_axis_video_tvalid (s_tvalid),
        .s_axis_video_tready (s_tready),
        .s_axis_video_tuser  (s_tuser),
        .s_axis_video_tlast  (s_tlast),
        .m_axis_video_tdata  (m_tdata),
        .m_axis_video_tvalid (m_valid),
        .m_axis_video_tready (m_ready),
        .m_axis_video_tuser  (m_tuser),
        .m_axis_video_tlast  (m_tlast)
    );

    typedef struct packed {
        logic [23:0] data;
        logic        user;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: q_i = (p_{i-1} + 2 p_i + p_{i+1}) / 4 with edge replication.
    function automatic int ref_q(input int l, input int c, input int r);
        int s;
        s = l + 2 * c + r;
`ifdef GREY_HBLUR_ROUND_EN
        s = s + 2;
`endif
        return s / 4;
    endfunction

    task automatic expect_line(input int pix[$], input logic sof);
        int n, l, r, q;
        beat_t b;
        n = pix.size();
        for (int i = 0; i < n; i++) begin
            l = (i == 0) ? pix[0] : pix[i-1];
            r = (i == n - 1) ? pix[i] : pix[i+1];
            q = ref_q(l, pix[i], r);
            b.data = {3{q[7:0]}};
            b.user = (i == 0) ? sof : 1'b0;
            b.last = (i == n - 1);
            exp_q.push_back(b);
        end
    endtask

    // Called just after a posedge; returns #1 after the accepting edge.
    task automatic send_beat(input logic [7:0] pix, input logic user, input logic last);
        logic [15:0] upper;
        bit ok;
        upper    = 16'($urandom());
        s_tdata  = {upper, pix};
        s_tuser  = user;
        s_tlast  = last;
        s_tvalid = 1'b1;
        ok = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1;
                break;
            end
        end
        chk("accept_bound", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_line(input int pix[$], input logic sof, input int gap_max);
        for (int i = 0; i < pix.size(); i++) begin
            int gap;
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send_beat(8'(pix[i]), (i == 0) ? sof : 1'b0, i == pix.size() - 1);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid) break;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every taken beat must match the model, in order;
    // a stalled beat must stay put until taken.
    logic        held = 1'b0;
    logic [23:0] held_data;
    always @(negedge clk) begin
        if (areset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data",  32'(m_tdata), 32'(held_data));
            end
            if (m_valid && m_ready) begin
                chk("extra_beat", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    $display("beat data=%06h user=%0b last=%0b (want %06h %0b %0b)",
                             m_tdata, m_tuser, m_tlast, e.data, e.user, e.last);
                    chk("out_data", 32'(m_tdata), 32'(e.data));
                    chk("out_user", 32'(m_tuser), 32'(e.user));
                    chk("out_last", 32'(m_tlast), 32'(e.last));
                end
            end
            held      = m_valid && !m_ready;
            held_data = m_tdata;
        end
    end

    // Random downstream backpressure, enabled for the random phase only.
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int          line[$];
        logic [7:0]  sp[8];
        logic        rdy_hist[13];
        int          idx, n_out;
        beat_t       first;

        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        m_ready  = 1'b1;
        rand_bp  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_valid",  32'(m_valid),  32'd0);
        chk("rst_m_tdata",  32'(m_tdata),  32'd0);
        chk("rst_m_tuser",  32'(m_tuser),  32'd0);
        chk("rst_m_tlast",  32'(m_tlast),  32'd0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(s_tready), 32'd1);
        @(posedge clk);
        #1;

        // Basic 4-pixel line
        line = {10, 20, 30, 40};
        expect_line(line, 1'b1);
        send_line(line, 1'b1, 0);
        wait_drain();

        // Single-pixel line: output two cycles after accept
        line = {200};
        expect_line(line, 1'b1);
        first = exp_q[0];
        send_beat(8'd200, 1'b1, 1'b1);
        @(negedge clk);
        chk("single_early", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("single_valid", 32'(m_valid), 32'd1);
        chk("single_data",  32'(m_tdata), 32'(first.data));
        wait_drain();

        // Saturated line: no wrap
        line = {255, 255, 255};
        expect_line(line, 1'b0);
        send_line(line, 1'b0, 1);
        wait_drain();

        // Backpressure on first output
        line = {0, 100, 0, 100};
        expect_line(line, 1'b1);
        first = exp_q[0];
        send_beat(8'd0, 1'b1, 1'b0);
        m_ready = 1'b0;
        send_beat(8'd100, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid",    32'(m_valid),  32'd1);
            chk("bp_data",     32'(m_tdata),  32'(first.data));
            chk("bp_s_tready", 32'(s_tready), 32'd0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send_beat(8'd0, 1'b0, 1'b0);
        send_beat(8'd100, 1'b0, 1'b1);
        wait_drain();

        // Reset in the middle of a line: stalled output is discarded
        send_beat(8'd5, 1'b1, 1'b0);
        m_ready = 1'b0;
        send_beat(8'd7, 1'b0, 1'b0);
        #2;
        areset = 1'b1;
        #1;
        chk("midrst_m_valid",  32'(m_valid),  32'd0);
        chk("midrst_s_tready", 32'(s_tready), 32'd0);
        chk("midrst_m_tdata",  32'(m_tdata),  32'd0);
        @(posedge clk);
        #1;
        areset  = 1'b0;
        m_ready = 1'b1;
        line = {8, 8};
        expect_line(line, 1'b1);
        send_line(line, 1'b1, 0);
        wait_drain();

        // Two back-to-back 4-pixel lines, tvalid/tready held high
        for (int i = 0; i < 8; i++) sp[i] = 8'($urandom());
        line = {sp[0], sp[1], sp[2], sp[3]};
        expect_line(line, 1'b1);
        line = {sp[4], sp[5], sp[6], sp[7]};
        expect_line(line, 1'b0);
        idx = 0;
        n_out = 0;
        s_tvalid = 1'b1;
        s_tdata  = {16'hA5A5, sp[0]};
        s_tuser  = 1'b1;
        s_tlast  = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            rdy_hist[c] = s_tready;
            if (c >= 2 && c <= 11 && m_valid && m_ready) n_out++;
            @(posedge clk);
            if (s_tvalid && rdy_hist[c]) idx++;
            #1;
            if (idx < 8) begin
                s_tdata = {16'h5A5A, sp[idx]};
                s_tuser = (idx == 0);
                s_tlast = (idx % 4 == 3);
            end else begin
                s_tvalid = 1'b0;
                s_tuser  = 1'b0;
                s_tlast  = 1'b0;
            end
        end
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("b2b_rdy_c%0d", c), 32'(rdy_hist[c]), 32'(!(c == 5 || c == 10)));
        end
        chk("b2b_out_count", 32'(n_out), 32'd8);
        chk("b2b_accepts",   32'(idx),   32'd8);
        wait_drain();

        // Random lines under random backpressure and input gaps
        rand_bp = 1'b1;
        for (int l = 0; l < 20; l++) begin
            int   len;
            logic sof;
            len = int'($urandom_range(1, 8));
            sof = 1'($urandom_range(0, 1));
            line.delete();
            for (int i = 0; i < len; i++) line.push_back(int'($urandom_range(0, 255)));
            expect_line(line, sof);
            send_line(line, sof, 2);
        end
        rand_bp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
